bus_timer: RTL and testbench

Bus-cycle termination stage sitting directly downstream of the rosco address decoder. Consumes the decoder's active-low chip selects plus ASn, inserts per-region wait states, forwards external acknowledges, and produces the active-high DTACK and BERR requests that the top level turns into open-drain DTACKn/BERRn. Its watchdog terminates any cycle nobody acknowledges with a bus error.

---
 rtl/rosco_pkg.sv | 18 +
 rtl/bus_timer_if.sv | 28 ++
 rtl/bus_timer_sync2.sv | 31 +++
 rtl/bus_timer.sv | 122 ++++++++++++
 tb/tb_bus_timer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rosco_pkg.sv
// Shared rosco definitions: bus-cycle state encoding and default timing constants.
package rosco_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EXT,
      ST_ACK,
      ST_BERR
   } bt_state_e;

   localparam int ROM_WAIT_DEF = 2;
   localparam int RAM_WAIT_DEF = 0;
   localparam int IO_WAIT_DEF  = 3;
   localparam int WD_LIMIT_DEF = 128;
   localparam int WD_WIDTH_DEF = 8;

endpackage

// File: rtl/bus_timer_if.sv
// CPU-side bus signals seen by the cycle-termination stage (all chip selects and acks active-low).
interface bus_timer_if;

   logic ASn;
   logic ROMSELn;
   logic RAMSELn;
   logic IOSELn;
   logic DUASELn;
   logic DUAIACKn;
   logic EXPSELn;
   logic EXTDTACKn;
   logic DUADTACKn;
   logic PDTACK;
   logic PBERR;

   modport master (
      output ASn, ROMSELn, RAMSELn, IOSELn, DUASELn, DUAIACKn, EXPSELn,
      output EXTDTACKn, DUADTACKn,
      input  PDTACK, PBERR
   );

   modport slave (
      input  ASn, ROMSELn, RAMSELn, IOSELn, DUASELn, DUAIACKn, EXPSELn,
      input  EXTDTACKn, DUADTACKn,
      output PDTACK, PBERR
   );

endinterface

// File: rtl/bus_timer_sync2.sv
// Two-flop synchroniser for asynchronous acknowledge inputs; reset value is a parameter.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/bus_timer.sv
// Bus-cycle termination: per-region wait states, external ack forwarding, DTACK/BERR requests.
// Define BUS_TIMER_WATCHDOG_EN to enable the watchdog that bus-errors unacknowledged cycles.
module bus_timer
   import rosco_pkg::*;
#(
   parameter int ROM_WAIT = ROM_WAIT_DEF,
   parameter int RAM_WAIT = RAM_WAIT_DEF,
   parameter int IO_WAIT  = IO_WAIT_DEF,
   parameter int WD_LIMIT = WD_LIMIT_DEF,
   parameter int WD_WIDTH = WD_WIDTH_DEF
) (
   input  logic        CLK,
   input  logic        RESETn,
   bus_timer_if.slave  bus
);

   logic extack_s, duack_s;

   sync2 #(.RST_VAL(1'b1)) u_sync_ext (.clk(CLK), .rst_n(RESETn), .d(bus.EXTDTACKn), .q(extack_s));
   sync2 #(.RST_VAL(1'b1)) u_sync_dua (.clk(CLK), .rst_n(RESETn), .d(bus.DUADTACKn), .q(duack_s));

   bt_state_e             state_q, state_d;
   logic [WD_WIDTH-1:0]   waitcnt_q, waitcnt_d;
   logic                  src_dua_q, src_dua_d;
   logic                  ack_n;
   logic                  internal;
   int unsigned           wsel;
`ifdef BUS_TIMER_WATCHDOG_EN
   logic [WD_WIDTH-1:0]   wdcnt_q, wdcnt_d;
`else
   wire                   unused_wd_limit = (WD_LIMIT > 0);
`endif

   always_comb begin
      state_d   = state_q;
      waitcnt_d = waitcnt_q;
      src_dua_d = src_dua_q;
      internal  = 1'b0;
      wsel      = 0;
`ifdef BUS_TIMER_WATCHDOG_EN
      wdcnt_d   = wdcnt_q;
`endif
      ack_n     = src_dua_q ? duack_s : extack_s;

      case (state_q)
         ST_IDLE: begin
            if (!bus.ASn) begin
               // Decoder selects are prioritised; anything unclaimed waits on the expansion ack.
               internal = 1'b1;
               if (!bus.ROMSELn)                      wsel = ROM_WAIT;
               else if (!bus.RAMSELn)                 wsel = RAM_WAIT;
               else if (!bus.DUASELn || !bus.DUAIACKn) begin
                  internal  = 1'b0;
                  src_dua_d = 1'b1;
               end
               else if (!bus.IOSELn)                  wsel = IO_WAIT;
               else begin
                  internal  = 1'b0;
                  src_dua_d = 1'b0;
               end

               if (!internal)      state_d = ST_EXT;
               else if (wsel == 0) state_d = ST_ACK;
               else begin
                  state_d   = ST_WAIT;
                  waitcnt_d = WD_WIDTH'(wsel - 1);
               end
`ifdef BUS_TIMER_WATCHDOG_EN
               wdcnt_d = '0;
`endif
            end
         end

         ST_WAIT, ST_EXT: begin
            if (bus.ASn)
               state_d = ST_IDLE;
            else if ((state_q == ST_WAIT) ? (waitcnt_q == '0) : !ack_n)
               state_d = ST_ACK;
            else begin
               if (waitcnt_q != '0) waitcnt_d = waitcnt_q - WD_WIDTH'(1);
`ifdef BUS_TIMER_WATCHDOG_EN
               // Expire on the edge that would bring the count to its limit; ack already won above.
               wdcnt_d = wdcnt_q + WD_WIDTH'(1);
               if (wdcnt_d == WD_WIDTH'(WD_LIMIT - 1)) state_d = ST_BERR;
`endif
            end
         end

         ST_ACK, ST_BERR: begin
            if (bus.ASn) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= ST_IDLE;
         waitcnt_q <= '0;
         src_dua_q <= 1'b0;
`ifdef BUS_TIMER_WATCHDOG_EN
         wdcnt_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         src_dua_q <= src_dua_d;
`ifdef BUS_TIMER_WATCHDOG_EN
         wdcnt_q   <= wdcnt_d;
`endif
      end
   end

   assign bus.PDTACK = (state_q == ST_ACK);
`ifdef BUS_TIMER_WATCHDOG_EN
   assign bus.PBERR  = (state_q == ST_BERR);
`else
   assign bus.PBERR  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: fixed vector table plus random cycles checked against a cycle-offset model.
module tb_bus_timer;

   localparam int ROM_W = 2;
   localparam int RAM_W = 0;
   localparam int IO_W  = 3;
   localparam int WDL   = 128;
`ifdef BUS_TIMER_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   // sel bits: [5]ROM [4]RAM [3]DUART [2]DUART-IACK [1]IO [0]EXP, active-high here
   typedef struct {
      logic [5:0] sel;
      int         ack_line;   // 0 = EXTDTACKn, 1 = DUADTACKn
      int         ack_at;     // ack driven low before edge N+ack_at, -1 never
      int         abort_at;   // ASn high before edge N+abort_at, -1 normal end
      int         hold;       // clocks ASn stays low after the response
      int         exp_off;    // response visible after edge N+exp_off
      int         exp_kind;   // 0 none, 1 DTACK, 2 BERR
   } vec_t;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   bus_timer_if bif ();

   bus_timer #(
      .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .WD_LIMIT(WDL), .WD_WIDTH(8)
   ) dut (
      .CLK(CLK), .RESETn(RESETn), .bus(bif.slave)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0b req=%0b", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bif.ASn = 1'b1;       bif.ROMSELn = 1'b1;  bif.RAMSELn = 1'b1;
      bif.DUASELn = 1'b1;   bif.DUAIACKn = 1'b1; bif.IOSELn = 1'b1;
      bif.EXPSELn = 1'b1;   bif.EXTDTACKn = 1'b1; bif.DUADTACKn = 1'b1;
   endtask

   function automatic vec_t mk(input logic [5:0] s, input int al, input int aa, input int ab,
                               input int h, input int off, input int kind);
      vec_t v;
      v.sel = s; v.ack_line = al; v.ack_at = aa; v.abort_at = ab;
      v.hold = h; v.exp_off = off; v.exp_kind = kind;
      return v;
   endfunction

   // Reference: decide region by priority, then response offset from wait count, sync delay or watchdog.
   function automatic void model(input logic [5:0] sel, input int ack_line, input int ack_at,
                                 input int abort_at, output int off, output int kind);
      int w; bit internal; int src; int t;
      internal = 1'b1; w = 0; src = 0;
      if (sel[5])               w = ROM_W;
      else if (sel[4])          w = RAM_W;
      else if (sel[3] | sel[2]) begin internal = 1'b0; src = 1; end
      else if (sel[1])          w = IO_W;
      else                      begin internal = 1'b0; src = 0; end
      if (internal) begin
         off = w; kind = 1;
      end else begin
         t = (ack_at >= 0 && ack_line == src) ? ack_at + 2 : -1;
         if (WD_EN && (t < 0 || t > WDL - 1)) begin off = WDL - 1; kind = 2; end
         else if (t < 0)                      begin off = 0;       kind = 0; end
         else                                 begin off = t;       kind = 1; end
      end
      if (kind != 0 && abort_at >= 0 && abort_at <= off) kind = 0;
   endfunction

   task automatic run_txn(input string tag, input vec_t v);
      int end_k;
      end_k = (v.abort_at >= 0) ? v.abort_at : v.exp_off + v.hold;
      for (int k = 0; k <= end_k; k++) begin
         @(negedge CLK);
         if (k < end_k) begin
            bif.ASn       = 1'b0;
            bif.ROMSELn   = ~v.sel[5];
            bif.RAMSELn   = ~v.sel[4];
            bif.DUASELn   = ~v.sel[3];
            bif.DUAIACKn  = ~v.sel[2];
            bif.IOSELn    = ~v.sel[1];
            bif.EXPSELn   = ~v.sel[0];
            bif.EXTDTACKn = !(v.ack_at >= 0 && k >= v.ack_at && v.ack_line == 0);
            bif.DUADTACKn = !(v.ack_at >= 0 && k >= v.ack_at && v.ack_line == 1);
         end else begin
            drive_idle();
         end
         @(posedge CLK); #1;
         check($sformatf("%s k%0d PDTACK", tag, k), bif.PDTACK,
               (k < end_k && v.exp_kind == 1 && k >= v.exp_off));
         check($sformatf("%s k%0d PBERR", tag, k), bif.PBERR,
               (k < end_k && v.exp_kind == 2 && k >= v.exp_off));
      end
      repeat (3) begin
         @(negedge CLK); drive_idle();
         @(posedge CLK); #1;
         check($sformatf("%s gap PDTACK", tag), bif.PDTACK, 1'b0);
         check($sformatf("%s gap PBERR", tag), bif.PBERR, 1'b0);
      end
   endtask

   initial begin
      vec_t v;
      int   off, kind;

      // Hand-derived vectors
      tbl.push_back(mk(6'b100000, 0, -1, -1, 2,  2, 1));  // ROM, 2 waits
      tbl.push_back(mk(6'b010000, 0, -1, -1, 3,  0, 1));  // RAM, zero wait
      tbl.push_back(mk(6'b000010, 0, -1, -1, 2,  3, 1));  // IO, 3 waits
      tbl.push_back(mk(6'b001000, 1,  4, -1, 2,  6, 1));  // DUART ack
      tbl.push_back(mk(6'b000100, 1,  1, -1, 1,  3, 1));  // DUART IACK
      tbl.push_back(mk(6'b000001, 0,  5, -1, 2,  7, 1));  // expansion ack 5 clocks in
      tbl.push_back(mk(6'b000001, 1,  1, 10, 0,  0, 0));  // wrong ack source, aborted
      tbl.push_back(mk(6'b000010, 0, -1,  1, 0,  0, 0));  // IO aborted at N+1
      tbl.push_back(mk(6'b000010, 0, -1,  3, 0,  0, 0));  // IO aborted on the ack edge
      tbl.push_back(mk(6'b100001, 0, -1, -1, 2,  2, 1));  // ROM beats EXP
      tbl.push_back(mk(6'b110000, 0, -1, -1, 2,  2, 1));  // ROM beats RAM
      tbl.push_back(mk(6'b001010, 1,  2, -1, 2,  4, 1));  // DUART beats IO
      tbl.push_back(mk(6'b000000, 0,  3, -1, 2,  5, 1));  // unmapped, ext ack
`ifdef BUS_TIMER_WATCHDOG_EN
      tbl.push_back(mk(6'b000000, 0, -1, -1, 2, 127, 2)); // unmapped, watchdog BERR
      tbl.push_back(mk(6'b001000, 1, 125, -1, 2, 127, 1)); // ack on the expiry edge wins
      tbl.push_back(mk(6'b000001, 0, 126, -1, 2, 127, 2)); // ack one edge too late
      tbl.push_back(mk(6'b000001, 1,   2, -1, 1, 127, 2)); // wrong source -> BERR
`else
      tbl.push_back(mk(6'b000000, 0, -1, 1000, 0, 0, 0)); // unmapped held 1000 clocks, no BERR
`endif

      // Reset held with a ROM cycle pending
      drive_idle();
      bif.ASn = 1'b0; bif.ROMSELn = 1'b0;
      RESETn = 1'b0;
      repeat (3) begin
         @(posedge CLK); #1;
         check("reset PDTACK", bif.PDTACK, 1'b0);
         check("reset PBERR", bif.PBERR, 1'b0);
      end
      @(posedge CLK); #2;
      RESETn = 1'b1;
      run_txn("reset_rom", mk(6'b100000, 0, -1, -1, 2, 2, 1));

      foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i]);

      // Random cycles against the model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 0) v.sel = 6'($urandom_range(0, 63));
         else v.sel = 6'(7'd1 << $urandom_range(0, 6));
         v.ack_line = int'($urandom_range(0, 1));
         v.ack_at   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 12));
         if (WD_EN && (i % 25 == 0)) v.ack_at = int'($urandom_range(122, 130));
         v.abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : -1;
         v.hold     = int'($urandom_range(1, 3));
         model(v.sel, v.ack_line, v.ack_at, v.abort_at, off, kind);
         if (kind == 0 && v.abort_at < 0) v.abort_at = 15;
         v.exp_off  = off;
         v.exp_kind = kind;
         run_txn($sformatf("rnd%0d", i), v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
